// File: rtl/alu_result_stage_if.sv
// Writeback bus between the ALU result stage and the register file.
// The stage drives data/valid and the register file answers with ready.
interface alu_result_stage_if #(
  parameter int REG_WIDTH = 8
);
  logic                 wb_valid;
  logic [REG_WIDTH-1:0] wb_data;
  logic [1:0]           wb_dst;
  logic                 wb_ready;

  modport master (
    output wb_valid,
    output wb_data,
    output wb_dst,
    input  wb_ready
  );

  modport slave (
    input  wb_valid,
    input  wb_data,
    input  wb_dst,
    output wb_ready
  );
endinterface

// File: rtl/alu_result_stage.sv
// 6502 ALU result stage: derives N/Z/C/V, applies the BCD decimal adjust,
// and hands the final value to the register file over a valid/ready writeback.
module alu_result_stage #(
  parameter int REG_WIDTH = 8
) (
  input  logic                 phi1,
  input  logic                 reset_n,
  input  logic [REG_WIDTH-1:0] alu_dout,
  input  logic                 alu_wout,
  input  logic                 alu_carry,
  input  logic                 alu_half_carry,
  input  logic                 op_a7,
  input  logic                 op_b7,
  input  logic                 is_sum,
  input  logic                 is_sub,
  input  logic                 dec_mode,
  input  logic [REG_WIDTH-1:0] status_in,
  input  logic [1:0]           dst_sel,
  alu_result_stage_if.master   wb,
  output logic [REG_WIDTH-1:0] status_out,
  output logic                 status_we,
  output logic                 busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ADJUST = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  localparam int C_BIT = 0;
  localparam int Z_BIT = 1;
  localparam int V_BIT = 6;
  localparam int N_BIT = 7;

  logic [1:0]           r_state;
  logic [REG_WIDTH-1:0] r_bin;
  logic                 r_carry;
  logic                 r_halfCarry;
  logic                 r_isSub;
  logic [1:0]           r_dst;
  logic [REG_WIDTH-1:0] r_status;
  logic [REG_WIDTH-1:0] r_statusOut;
  logic                 r_statusWe;
  logic                 r_wbValid;
  logic [REG_WIDTH-1:0] r_wbData;
  logic [1:0]           r_wbDst;

  logic                 w_negative;
  logic                 w_zero;
  logic                 w_overflow;
  logic [REG_WIDTH-1:0] w_status;

  logic                 w_addLoFix;
  logic [REG_WIDTH-1:0] w_addStep;
  logic                 w_addHiFix;
  logic [REG_WIDTH-1:0] w_addResult;
  logic [REG_WIDTH-1:0] w_subResult;
  logic [REG_WIDTH-1:0] w_adjResult;
  logic                 w_adjCarry;
  logic [REG_WIDTH-1:0] w_adjStatus;

  // N and Z always reflect the binary ALU value, even in decimal mode (NMOS behaviour).
  assign w_negative = alu_dout[N_BIT];
  assign w_zero     = (alu_dout == '0);
  assign w_overflow = (op_a7 == op_b7) && (alu_dout[N_BIT] != op_a7);

  always_comb begin
    w_status        = status_in;
    w_status[N_BIT] = w_negative;
    w_status[Z_BIT] = w_zero;
    if (is_sum) begin
      w_status[V_BIT] = w_overflow;
      w_status[C_BIT] = alu_carry;
    end
  end

  // Decimal add: the low-nibble fix may carry into the high nibble before it is checked.
  assign w_addLoFix = r_halfCarry || (r_bin[3:0] > 4'd9);
  assign w_addStep  = w_addLoFix ? (r_bin + REG_WIDTH'(6)) : r_bin;
  assign w_addHiFix = r_carry || (w_addStep[7:4] > 4'd9);

  always_comb begin
    w_addResult = w_addStep;
    if (w_addHiFix) begin
      w_addResult[7:4] = w_addStep[7:4] + 4'd6;
    end
  end

  // Decimal subtract: each nibble is corrected independently, no borrow between them.
  always_comb begin
    w_subResult = r_bin;
    if (!r_halfCarry) begin
      w_subResult[3:0] = r_bin[3:0] - 4'd6;
    end
    if (!r_carry) begin
      w_subResult[7:4] = r_bin[7:4] - 4'd6;
    end
  end

  assign w_adjResult = r_isSub ? w_subResult : w_addResult;
  assign w_adjCarry  = r_carry || (!r_isSub && w_addHiFix);

  always_comb begin
    w_adjStatus        = r_status;
    w_adjStatus[C_BIT] = w_adjCarry;
  end

  // Writes from the ALU are only sampled in IDLE; while busy they are dropped.
  always_ff @(posedge phi1) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_bin       <= '0;
      r_carry     <= 1'b0;
      r_halfCarry <= 1'b0;
      r_isSub     <= 1'b0;
      r_dst       <= 2'd0;
      r_status    <= '0;
      r_statusOut <= '0;
      r_statusWe  <= 1'b0;
      r_wbValid   <= 1'b0;
      r_wbData    <= '0;
      r_wbDst     <= 2'd0;
    end else begin
      r_statusWe <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (alu_wout) begin
            r_bin       <= alu_dout;
            r_carry     <= alu_carry;
            r_halfCarry <= alu_half_carry;
            r_isSub     <= is_sub;
            r_dst       <= dst_sel;
            r_status    <= w_status;
            if (is_sum && dec_mode) begin
              r_state <= ST_ADJUST;
            end else begin
              r_statusOut <= w_status;
              r_statusWe  <= 1'b1;
              if (dst_sel != 2'd0) begin
                r_wbData  <= alu_dout;
                r_wbDst   <= dst_sel;
                r_wbValid <= 1'b1;
                r_state   <= ST_HOLD;
              end
            end
          end
        end
        ST_ADJUST: begin
          r_statusOut <= w_adjStatus;
          r_statusWe  <= 1'b1;
          if (r_dst != 2'd0) begin
            r_wbData  <= w_adjResult;
            r_wbDst   <= r_dst;
            r_wbValid <= 1'b1;
            r_state   <= ST_HOLD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (wb.wb_ready) begin
            r_wbValid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign wb.wb_valid = r_wbValid;
  assign wb.wb_data  = r_wbData;
  assign wb.wb_dst   = r_wbDst;
  assign status_out  = r_statusOut;
  assign status_we   = r_statusWe;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: binary/decimal results, flags,
// writeback backpressure, flag-only ops and reset during ADJUST.
module tb_alu_result_stage;

  logic       phi1 = 1'b0;
  logic       reset_n;
  logic [7:0] alu_dout;
  logic       alu_wout;
  logic       alu_carry;
  logic       alu_half_carry;
  logic       op_a7;
  logic       op_b7;
  logic       is_sum;
  logic       is_sub;
  logic       dec_mode;
  logic [7:0] status_in;
  logic [1:0] dst_sel;
  logic [7:0] status_out;
  logic       status_we;
  logic       busy;

  int assertCount = 0;
  int failCount   = 0;

  alu_result_stage_if #(.REG_WIDTH(8)) wbIf ();

  alu_result_stage #(.REG_WIDTH(8)) dut (
    .phi1           (phi1),
    .reset_n        (reset_n),
    .alu_dout       (alu_dout),
    .alu_wout       (alu_wout),
    .alu_carry      (alu_carry),
    .alu_half_carry (alu_half_carry),
    .op_a7          (op_a7),
    .op_b7          (op_b7),
    .is_sum         (is_sum),
    .is_sub         (is_sub),
    .dec_mode       (dec_mode),
    .status_in      (status_in),
    .dst_sel        (dst_sel),
    .wb             (wbIf),
    .status_out     (status_out),
    .status_we      (status_we),
    .busy           (busy)
  );

  always #5 phi1 = ~phi1;

  task automatic stepClock();
    @(posedge phi1);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] dout, input logic carry, input logic hc,
                               input logic a7, input logic b7, input logic sum,
                               input logic sub, input logic dec, input logic [7:0] stIn,
                               input logic [1:0] dst);
    alu_dout       = dout;
    alu_carry      = carry;
    alu_half_carry = hc;
    op_a7          = a7;
    op_b7          = b7;
    is_sum         = sum;
    is_sub         = sub;
    dec_mode       = dec;
    status_in      = stIn;
    dst_sel        = dst;
    alu_wout       = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    alu_dout       = 8'h00;
    alu_wout       = 1'b0;
    alu_carry      = 1'b0;
    alu_half_carry = 1'b0;
    op_a7          = 1'b0;
    op_b7          = 1'b0;
    is_sum         = 1'b0;
    is_sub         = 1'b0;
    dec_mode       = 1'b0;
    status_in      = 8'h00;
    dst_sel        = 2'd0;
    wbIf.wb_ready  = 1'b0;

    stepClock();
    stepClock();
    checkOutput("rst_valid",  32'(wbIf.wb_valid), 32'h0);
    checkOutput("rst_data",   32'(wbIf.wb_data),  32'h0);
    checkOutput("rst_dst",    32'(wbIf.wb_dst),   32'h0);
    checkOutput("rst_status", 32'(status_out),    32'h0);
    checkOutput("rst_we",     32'(status_we),     32'h0);
    checkOutput("rst_busy",   32'(busy),          32'h0);
    reset_n = 1'b1;

    // Binary ADC 0xFF+0x01 -> 0x00 with carry out: Z=1, C=1, V=0
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 2'd1);
    stepClock();
    alu_wout = 1'b0;
    checkOutput("adc_valid",  32'(wbIf.wb_valid), 32'h1);
    checkOutput("adc_data",   32'(wbIf.wb_data),  32'h00);
    checkOutput("adc_dst",    32'(wbIf.wb_dst),   32'h1);
    checkOutput("adc_status", 32'(status_out),    32'h23);
    checkOutput("adc_we",     32'(status_we),     32'h1);
    checkOutput("adc_busy",   32'(busy),          32'h1);
    wbIf.wb_ready = 1'b1;
    stepClock();
    checkOutput("adc_we_drop",  32'(status_we),     32'h0);
    checkOutput("adc_hs_valid", 32'(wbIf.wb_valid), 32'h0);
    checkOutput("adc_hs_busy",  32'(busy),          32'h0);

    // Signed overflow: two positives giving 0xA0
    applyStimulus(8'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 2'd2);
    stepClock();
    alu_wout = 1'b0;
    checkOutput("ovf_data",   32'(wbIf.wb_data), 32'hA0);
    checkOutput("ovf_dst",    32'(wbIf.wb_dst),  32'h2);
    checkOutput("ovf_status", 32'(status_out),   32'hE0);
    stepClock();
    checkOutput("ovf_idle", 32'(busy), 32'h0);

    // Decimal ADC 0x19+0x28: binary 0x41 with half carry -> 0x47
    applyStimulus(8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h28, 2'd1);
    stepClock();
    alu_wout = 1'b0;
    checkOutput("dadd_adj_busy",  32'(busy),          32'h1);
    checkOutput("dadd_adj_valid", 32'(wbIf.wb_valid), 32'h0);
    checkOutput("dadd_adj_we",    32'(status_we),     32'h0);
    stepClock();
    checkOutput("dadd_valid",  32'(wbIf.wb_valid), 32'h1);
    checkOutput("dadd_data",   32'(wbIf.wb_data),  32'h47);
    checkOutput("dadd_status", 32'(status_out),    32'h28);
    checkOutput("dadd_we",     32'(status_we),     32'h1);
    stepClock();
    checkOutput("dadd_idle", 32'(busy), 32'h0);

    // Decimal ADC 0x99+0x01: binary 0x9A -> 0x00 with C=1, Z from binary stays 0
    applyStimulus(8'h9A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h28, 2'd1);
    stepClock();
    alu_wout = 1'b0;
    stepClock();
    checkOutput("dwrap_data",   32'(wbIf.wb_data), 32'h00);
    checkOutput("dwrap_status", 32'(status_out),   32'hA9);
    stepClock();

    // Decimal SBC 0x50-0x01: binary 0x4F, no half carry, carry=1 -> 0x49
    applyStimulus(8'h4F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h28, 2'd2);
    stepClock();
    alu_wout = 1'b0;
    stepClock();
    checkOutput("dsub_data",   32'(wbIf.wb_data), 32'h49);
    checkOutput("dsub_dst",    32'(wbIf.wb_dst),  32'h2);
    checkOutput("dsub_status", 32'(status_out),   32'h29);
    stepClock();

    // Backpressure: non-sum op to Y, ready held low, stray write mid-hold
    wbIf.wb_ready = 1'b0;
    applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h61, 2'd3);
    stepClock();
    alu_wout = 1'b0;
    checkOutput("bp_status", 32'(status_out), 32'h61);
    checkOutput("bp_we",     32'(status_we),  32'h1);
    stepClock();
    checkOutput("bp_hold1_valid", 32'(wbIf.wb_valid), 32'h1);
    checkOutput("bp_hold1_we",    32'(status_we),     32'h0);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd1);
    stepClock();
    alu_wout = 1'b0;
    checkOutput("bp_hold2_data",   32'(wbIf.wb_data), 32'h55);
    checkOutput("bp_hold2_dst",    32'(wbIf.wb_dst),  32'h3);
    checkOutput("bp_hold2_status", 32'(status_out),   32'h61);
    checkOutput("bp_hold2_we",     32'(status_we),    32'h0);
    stepClock();
    checkOutput("bp_hold3_valid", 32'(wbIf.wb_valid), 32'h1);
    checkOutput("bp_hold3_busy",  32'(busy),          32'h1);
    checkOutput("bp_hold3_data",  32'(wbIf.wb_data),  32'h55);
    wbIf.wb_ready = 1'b1;
    stepClock();
    checkOutput("bp_rel_valid", 32'(wbIf.wb_valid), 32'h0);
    checkOutput("bp_rel_busy",  32'(busy),          32'h0);
    stepClock();
    checkOutput("bp_nocap_valid", 32'(wbIf.wb_valid), 32'h0);

    // Flag-only AND result 0x00: Z set, C/V kept from status_in
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41, 2'd0);
    stepClock();
    alu_wout = 1'b0;
    checkOutput("flag_status", 32'(status_out),    32'h43);
    checkOutput("flag_we",     32'(status_we),     32'h1);
    checkOutput("flag_valid",  32'(wbIf.wb_valid), 32'h0);
    checkOutput("flag_busy",   32'(busy),          32'h0);
    stepClock();
    checkOutput("flag_we_drop", 32'(status_we),     32'h0);
    checkOutput("flag_valid2",  32'(wbIf.wb_valid), 32'h0);

    // Reset while in ADJUST drops the transaction
    applyStimulus(8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h28, 2'd1);
    stepClock();
    alu_wout = 1'b0;
    checkOutput("radj_busy", 32'(busy), 32'h1);
    reset_n = 1'b0;
    stepClock();
    checkOutput("radj_valid",  32'(wbIf.wb_valid), 32'h0);
    checkOutput("radj_data",   32'(wbIf.wb_data),  32'h0);
    checkOutput("radj_status", 32'(status_out),    32'h0);
    checkOutput("radj_we",     32'(status_we),     32'h0);
    checkOutput("radj_busy0",  32'(busy),          32'h0);
    reset_n = 1'b1;
    stepClock();
    checkOutput("radj_dropped", 32'(wbIf.wb_valid), 32'h0);
    applyStimulus(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 2'd2);
    stepClock();
    alu_wout = 1'b0;
    checkOutput("post_rst_valid", 32'(wbIf.wb_valid), 32'h1);
    checkOutput("post_rst_data",  32'(wbIf.wb_data),  32'h12);
    stepClock();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
